rf_nr_1w_clr: RTL
=================

Name: rf_nr_1w_clr

Overview:
- Parametrised successor to the fixed 16x32 single-read register file: configurable width, depth and number of read ports, plus one write port.
- Adds optional registered reads, optional write-to-read bypass, and a hardware clear sequencer. The sequencer zeroes every entry after reset and on request.
- Used as the general register-file macro in the emulation build. Serves GIP register banks and descriptor stores.

Parameters:
- WIDTH, 32, data bits per entry.
- ADDR_BITS, 4, address bits; DEPTH = 2**ADDR_BITS entries.
- READ_PORTS, 2, number of independent read ports (1..4).
- REG_READ, 1, 1 = read data registered (1-cycle latency); 0 = combinational read.
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port; 0 = no forwarding.

Ports:
- rf_clock  input  1  sole clock, rising edge.
- rf_reset  input  1  asynchronous, active-low reset.
- rf_rd_addr  input  READ_PORTS*ADDR_BITS  packed read addresses; port p uses bits [p*ADDR_BITS +: ADDR_BITS].
- rf_rd_data  output  READ_PORTS*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].
- rf_wr_enable  input  1  write strobe, sampled at rising edge.
- rf_wr_addr  input  ADDR_BITS  write address.
- rf_wr_data  input  WIDTH  write data.
- rf_clear  input  1  single-cycle request to zero all entries.
- rf_busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (rf_reset low, asynchronous):
  - state=CLEAR, clr_addr=0, rf_busy=1.
  - All registered read outputs = 0.
  - Array contents undefined until the sweep completes.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each rising edge writes 0 to entry clr_addr, then clr_addr increments.
  - On the edge that writes entry DEPTH-1, state goes to IDLE and clr_addr wraps to 0.
  - rf_busy is high for exactly DEPTH cycles after reset release, or after the cycle rf_clear is accepted.
- IDLE: rf_clear=1 at an edge moves state to CLEAR with clr_addr=0; rf_busy=1 from the next cycle.
- rf_clear while in CLEAR is ignored; the sweep is not restarted.
- Writes:
  - In IDLE with rf_wr_enable=1 and rf_clear=0, the array entry rf_wr_addr takes rf_wr_data at the edge.
  - Writes are dropped while rf_busy=1.
  - Writes are dropped in the cycle rf_clear is accepted (clear has priority).
- Reads, per port p, are independent of the other ports. All ports may address the same entry.
  - Source value = array[addr_p].
  - If BYPASS=1, rf_busy=0, rf_wr_enable=1 and rf_wr_addr==addr_p, the source value is rf_wr_data instead.
  - While rf_busy=1 the source value is forced to 0.
- REG_READ=0: rf_rd_data reflects the source value combinationally. With BYPASS=0, a same-cycle write is visible only after the edge.
- REG_READ=1:
  - rf_rd_data[p] loads the source value at each rising edge; latency 1 cycle.
  - With BYPASS=1, a write and a read of the same address in cycle N yield the new data in cycle N+1.
  - With BYPASS=0, the same case yields the old data in cycle N+1.
- A read of an entry just zeroed, once rf_busy=0, returns 0.
- Address width is exact. Every address in 0..DEPTH-1 is valid; there is no out-of-range case.

Test Plan:
- Parameter set for all scenarios: WIDTH=32, ADDR_BITS=4, READ_PORTS=2, REG_READ=1, BYPASS=1.
- Release rf_reset, hold writes at addr 3 = 0xDEADBEEF throughout -> rf_busy=1 for 16 cycles, then 0. Afterwards all 16 entries read 0x00000000; the addr 3 write was dropped.
- In IDLE, write addr 5 = 0x12345678 while port0 reads addr 5 in the same cycle -> port0 = 0x12345678 the next cycle (bypass). Rerun with BYPASS=0 -> port0 returns 0 next cycle, 0x12345678 the cycle after.
- Write 0xA5A5A5A5 to addr 15 and 0x0000FFFF to addr 0. Port0 reads 15, port1 reads 0 on the same cycle -> next cycle port0=0xA5A5A5A5, port1=0x0000FFFF.
- Fill all entries with value = addr, then pulse rf_clear with a simultaneous write to addr 2 = 0x77 -> rf_busy high 16 cycles, reads return 0 during busy. Afterwards every entry is 0, including addr 2.
- Pulse rf_clear at cycle 4 of an active sweep -> busy still ends 16 cycles after the original start (no restart).
- Assert rf_reset mid-sweep and mid-operation with the array filled -> rf_rd_data=0 and rf_busy=1 immediately, without waiting for a clock edge. After release, a full 16-cycle sweep occurs and all entries read 0.

Source files
------------

// File: rtl/rf_nr_1w_clr.sv
// rtl/rf_nr_1w_clr.sv - parametrised multi-read, single-write register file with clear sweep
module rf_nr_1w_clr #(
    parameter int WIDTH      = 32,
    parameter int ADDR_BITS  = 4,
    parameter int READ_PORTS = 2,
    parameter int REG_READ   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             rf_clock,
    input  logic                             rf_reset,
    input  logic [READ_PORTS*ADDR_BITS-1:0]  rf_rd_addr,
    output logic [READ_PORTS*WIDTH-1:0]      rf_rd_data,
    input  logic                             rf_wr_enable,
    input  logic [ADDR_BITS-1:0]             rf_wr_addr,
    input  logic [WIDTH-1:0]                 rf_wr_data,
    input  logic                             rf_clear,
    output logic                             rf_busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_clr_addr;
    logic [ADDR_BITS-1:0]   w_clr_addr_nxt;
    logic                   w_wr_accept;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    // Sequencer state and sweep pointer; reset lands in a fresh sweep
    always_ff @(posedge rf_clock or negedge rf_reset) begin
        if (!rf_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next-state logic: the sweep runs to the last entry; clear beats a same-cycle write
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        rf_busy        = 1'b0;
        w_wr_accept    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                rf_busy        = 1'b1;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rf_clear) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_wr_accept = rf_wr_enable;
                end
            end
            default: begin
                w_state_nxt    = ST_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Storage array: the sweep owns the write port while busy
    always_ff @(posedge rf_clock) begin
        if (rf_busy) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[rf_wr_addr] <= rf_wr_data;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_BITS-1:0] w_addr;
        logic [WIDTH-1:0]     w_src;

        assign w_addr = rf_rd_addr[p*ADDR_BITS +: ADDR_BITS];

        // Source value: array, optionally overridden by a matching write, zero while sweeping
        always_comb begin
            w_src = r_mem[w_addr];
            if ((BYPASS != 0) && !rf_busy && rf_wr_enable && (rf_wr_addr == w_addr)) begin
                w_src = rf_wr_data;
            end
            if (rf_busy) begin
                w_src = '0;
            end
        end

        if (REG_READ != 0) begin : g_reg
            logic [WIDTH-1:0] r_rd;

            // Registered read output, cleared asynchronously with the sequencer
            always_ff @(posedge rf_clock or negedge rf_reset) begin
                if (!rf_reset) begin
                    r_rd <= '0;
                end else begin
                    r_rd <= w_src;
                end
            end

            assign rf_rd_data[p*WIDTH +: WIDTH] = r_rd;
        end else begin : g_comb
            assign rf_rd_data[p*WIDTH +: WIDTH] = w_src;
        end
    end

endmodule
